// File: rtl/rvc_asap_pkg.sv
// rvc_asap_pkg: shared types and constants for the rvc_asap 5-stage core.
package rvc_asap_pkg;

    typedef enum logic [1:0] {RUN, DRAIN, LOAD} t_i_mem_ctrl_state;

    localparam logic [31:0] I_MEM_MSB = 32'h0000_0FFF;

endpackage

// File: rtl/rvc_asap_5pl_i_mem_ctrl.sv
// rvc_asap_5pl_i_mem_ctrl: arbitrates the single I_MEM port between the fetch stage and a loader,
// halting and draining the core before handing the port over.
module rvc_asap_5pl_i_mem_ctrl #(
    parameter bit          BOOT_LOAD = 1'b1,
    parameter logic [31:0] I_MEM_MSB = rvc_asap_pkg::I_MEM_MSB
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        core_fetch_en,
    input  logic [31:0] core_pc,
    output logic [31:0] core_instr,
    output logic        core_instr_valid,
    output logic        core_halt,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic        ld_we,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_wdata,
    output logic [31:0] ld_rdata,
    output logic        ld_rvalid,
    input  logic        ld_done,
    output logic        ld_err,
    output logic [15:0] ld_wr_cnt,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_q
);
    import rvc_asap_pkg::*;

    t_i_mem_ctrl_state state_q, state_d;
    logic        civ_q, lrv_q, err_q, err_d;
    logic [15:0] cnt_q, cnt_d;
    logic        legal, acc;

    assign legal = (ld_addr[1:0] == 2'b00) && (ld_addr <= I_MEM_MSB - 32'd3);
    assign acc   = (state_q == LOAD) && ld_valid;

    always_comb begin
        state_d  = state_q;
        mem_addr = ld_addr;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        case (state_q)
            RUN: begin
                mem_addr = core_pc;
                mem_rd   = core_fetch_en;
                state_d  = ld_valid ? DRAIN : RUN;
            end
            DRAIN: state_d = LOAD;
            LOAD: begin
                mem_rd  = acc && legal && !ld_we;
                mem_wr  = acc && legal && ld_we;
                state_d = ld_done ? RUN : LOAD;
            end
            default: state_d = BOOT_LOAD ? LOAD : RUN;
        endcase
        // Keep the memory quiet while reset is held, even with live requesters.
        mem_rd = mem_rd && rst_n;
        mem_wr = mem_wr && rst_n;
    end

    // An illegal access accepted alongside ld_done must not survive the release.
    assign err_d = ((state_q == LOAD) && ld_done) ? 1'b0 : (err_q || (acc && !legal));
    assign cnt_d = (mem_wr && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT_LOAD ? LOAD : RUN;
            civ_q   <= 1'b0;
            lrv_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            civ_q   <= (state_q == RUN) && mem_rd;
            lrv_q   <= (state_q == LOAD) && mem_rd;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign core_halt        = (state_q != RUN);
    assign ld_ready         = (state_q == LOAD);
    assign core_instr       = mem_q;
    assign ld_rdata         = mem_q;
    assign core_instr_valid = civ_q;
    assign ld_rvalid        = lrv_q;
    assign ld_err           = err_q;
    assign ld_wr_cnt        = cnt_q;
    assign mem_wdata        = ld_wdata;

endmodule

// File: tb/tb_rvc_asap_5pl_i_mem_ctrl.sv
// tb_rvc_asap_5pl_i_mem_ctrl: random and directed stimulus against a transaction-level model
// of port ownership, loader writes and read returns, plus a BOOT_LOAD=0 instance for reset checks.
module tb_rvc_asap_5pl_i_mem_ctrl;

    localparam logic [31:0] MSB = 32'h0000_0FFF;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        core_fetch_en = 1'b0;
    logic [31:0] core_pc = '0;
    logic        ld_valid = 1'b0, ld_we = 1'b0, ld_done = 1'b0;
    logic [31:0] ld_addr = '0, ld_wdata = '0;
    logic [31:0] mem_q;

    logic [31:0] core_instr, ld_rdata, mem_addr, mem_wdata;
    logic        core_instr_valid, core_halt, ld_ready, ld_rvalid, ld_err, mem_rd, mem_wr;
    logic [15:0] ld_wr_cnt;

    logic [31:0] d0_core_instr, d0_ld_rdata, d0_mem_addr, d0_mem_wdata;
    logic        d0_civ, d0_core_halt, d0_ld_ready, d0_lrv, d0_ld_err, d0_mem_rd, d0_mem_wr;
    logic [15:0] d0_ld_wr_cnt;

    always #5 clock = ~clock;

    rvc_asap_5pl_i_mem_ctrl #(.BOOT_LOAD(1'b1), .I_MEM_MSB(MSB)) dut (
        .clock(clock), .rst_n(rst_n), .core_fetch_en(core_fetch_en), .core_pc(core_pc),
        .core_instr(core_instr), .core_instr_valid(core_instr_valid), .core_halt(core_halt),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_wdata(ld_wdata), .ld_rdata(ld_rdata), .ld_rvalid(ld_rvalid), .ld_done(ld_done),
        .ld_err(ld_err), .ld_wr_cnt(ld_wr_cnt), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_q(mem_q));

    rvc_asap_5pl_i_mem_ctrl #(.BOOT_LOAD(1'b0), .I_MEM_MSB(MSB)) dut0 (
        .clock(clock), .rst_n(rst_n), .core_fetch_en(core_fetch_en), .core_pc(core_pc),
        .core_instr(d0_core_instr), .core_instr_valid(d0_civ), .core_halt(d0_core_halt),
        .ld_valid(ld_valid), .ld_ready(d0_ld_ready), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_wdata(ld_wdata), .ld_rdata(d0_ld_rdata), .ld_rvalid(d0_lrv), .ld_done(ld_done),
        .ld_err(d0_ld_err), .ld_wr_cnt(d0_ld_wr_cnt), .mem_addr(d0_mem_addr), .mem_rd(d0_mem_rd),
        .mem_wr(d0_mem_wr), .mem_wdata(d0_mem_wdata), .mem_q(mem_q));

    // I_MEM stand-in: synchronous read, write at the edge.
    logic [31:0] imem [0:1023];
    always @(posedge clock) begin
        if (mem_wr) imem[mem_addr[11:2]] <= mem_wdata;
        if (mem_rd) mem_q <= imem[mem_addr[11:2]];
    end

    int n_chk = 0, n_fail = 0;

    // Model: who owns the port (0 core, 1 handover, 2 loader), what the loader has written,
    // and what read result is owed next cycle.
    int          m_mode = 2;
    logic [31:0] shadow [0:1023];
    logic        m_pend_core = 1'b0, m_pend_ld = 1'b0, m_err = 1'b0;
    logic [31:0] m_pend_data = '0;
    int          m_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 2; m_pend_core = 1'b0; m_pend_ld = 1'b0; m_err = 1'b0; m_cnt = 0;
    endtask

    task automatic step();
        logic        acc, legal, erd, ewr;
        logic [31:0] a;
        @(negedge clock);
        acc   = (m_mode == 2) && ld_valid;
        legal = (ld_addr[1:0] == 2'b00) && (ld_addr <= MSB - 32'd3);
        erd   = (m_mode == 0) ? core_fetch_en : (acc && legal && !ld_we);
        ewr   = acc && legal && ld_we;
        a     = (m_mode == 0) ? core_pc : ld_addr;
        chk("core_halt", 32'(core_halt), 32'(m_mode != 0));
        chk("ld_ready", 32'(ld_ready), 32'(m_mode == 2));
        chk("mem_rd", 32'(mem_rd), 32'(erd));
        chk("mem_wr", 32'(mem_wr), 32'(ewr));
        chk("core_instr_valid", 32'(core_instr_valid), 32'(m_pend_core));
        chk("ld_rvalid", 32'(ld_rvalid), 32'(m_pend_ld));
        chk("ld_err", 32'(ld_err), 32'(m_err));
        chk("ld_wr_cnt", 32'(ld_wr_cnt), 32'(m_cnt));
        if (m_pend_core) chk("core_instr", core_instr, m_pend_data);
        if (m_pend_ld) chk("ld_rdata", ld_rdata, m_pend_data);
        if (erd || ewr) chk("mem_addr", mem_addr, a);
        if (ewr) chk("mem_wdata", mem_wdata, ld_wdata);
        m_pend_core = (m_mode == 0) && core_fetch_en;
        m_pend_ld   = acc && legal && !ld_we;
        m_pend_data = shadow[a[11:2]];
        if (ewr) begin
            shadow[a[11:2]] = ld_wdata;
            if (m_cnt < 65535) m_cnt++;
        end
        if (m_mode == 2 && ld_done) m_err = 1'b0;
        else if (acc && !legal) m_err = 1'b1;
        m_mode = (m_mode == 0) ? (ld_valid ? 1 : 0) : (m_mode == 1) ? 2 : (ld_done ? 0 : 2);
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        core_fetch_en = 1'b0; ld_valid = 1'b0; ld_we = 1'b0; ld_done = 1'b0;
    endtask

    task automatic ld(input logic v, input logic we, input logic [31:0] ad, input logic [31:0] wd,
                      input logic dn);
        ld_valid = v; ld_we = we; ld_addr = ad; ld_wdata = wd; ld_done = dn;
    endtask

    initial begin
        logic [31:0] odd_addrs [4];
        odd_addrs[0] = 32'h0000_0FFC; odd_addrs[1] = 32'h0000_1000;
        odd_addrs[2] = 32'h0000_0FFE; odd_addrs[3] = 32'h0000_0FFD;
        for (int i = 0; i < 1024; i++) begin
            imem[i] = '0;
            shadow[i] = '0;
        end
        // Reset state, observed while reset is held with the core requesting.
        core_fetch_en = 1'b1;
        repeat (2) @(posedge clock);
        #2;
        chk("rst core_halt", 32'(core_halt), 32'd1);
        chk("rst ld_ready", 32'(ld_ready), 32'd1);
        chk("rst core_instr_valid", 32'(core_instr_valid), 32'd0);
        chk("rst ld_rvalid", 32'(ld_rvalid), 32'd0);
        chk("rst ld_err", 32'(ld_err), 32'd0);
        chk("rst ld_wr_cnt", 32'(ld_wr_cnt), 32'd0);
        chk("rst d0 core_halt", 32'(d0_core_halt), 32'd0);
        chk("rst d0 mem_rd", 32'(d0_mem_rd), 32'd0);
        idle();
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        model_reset();

        // Boot load then fetch the loaded words.
        ld(1'b1, 1'b1, 32'h0, 32'h0000_0013, 1'b0); step();
        ld(1'b1, 1'b1, 32'h4, 32'h0010_0093, 1'b0); step();
        ld(1'b0, 1'b0, 32'h0, 32'h0, 1'b1); step();
        ld_done = 1'b0;
        chk("boot ld_wr_cnt", 32'(ld_wr_cnt), 32'd2);
        chk("boot core_halt", 32'(core_halt), 32'd0);
        core_fetch_en = 1'b1; core_pc = 32'h0; step();
        chk("fetch0 valid", 32'(core_instr_valid), 32'd1);
        chk("fetch0 instr", core_instr, 32'h0000_0013);
        core_pc = 32'h4; step();
        chk("fetch4 valid", 32'(core_instr_valid), 32'd1);
        chk("fetch4 instr", core_instr, 32'h0010_0093);

        // Handover with a fetch in the same cycle as the first ld_valid.
        core_pc = 32'h8;
        ld(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0); step();
        chk("drain civ", 32'(core_instr_valid), 32'd1);
        chk("drain ld_ready", 32'(ld_ready), 32'd0);
        chk("drain mem_rd", 32'(mem_rd), 32'd0);
        step();
        chk("load ld_ready", 32'(ld_ready), 32'd1);
        step();
        chk("wr cnt 3", 32'(ld_wr_cnt), 32'd3);
        ld(1'b1, 1'b0, 32'h10, 32'h0, 1'b0); step();
        chk("readback rvalid", 32'(ld_rvalid), 32'd1);
        chk("readback data", ld_rdata, 32'hDEAD_BEEF);
        chk("readback civ", 32'(core_instr_valid), 32'd0);

        // Illegal accesses.
        core_fetch_en = 1'b0;
        ld(1'b1, 1'b1, 32'h3, 32'h1234_5678, 1'b0); step();
        chk("illegal err", 32'(ld_err), 32'd1);
        chk("illegal cnt", 32'(ld_wr_cnt), 32'd3);
        ld(1'b1, 1'b0, MSB - 32'd1, 32'h0, 1'b0); step();
        chk("illegal rvalid", 32'(ld_rvalid), 32'd0);
        ld(1'b0, 1'b0, 32'h0, 32'h0, 1'b0); step();
        chk("err sticky", 32'(ld_err), 32'd1);

        // Read accepted together with ld_done.
        ld(1'b1, 1'b0, 32'h10, 32'h0, 1'b1); step();
        idle();
        chk("simul rvalid", 32'(ld_rvalid), 32'd1);
        chk("simul rdata", ld_rdata, 32'hDEAD_BEEF);
        chk("simul core_halt", 32'(core_halt), 32'd0);
        chk("simul err clear", 32'(ld_err), 32'd0);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            int r;
            core_fetch_en = 1'($urandom % 2);
            core_pc = 32'($urandom_range(0, 1023)) << 2;
            ld_valid = ($urandom % 3) == 0;
            ld_done = ($urandom % 12) == 0;
            ld_we = 1'($urandom % 2);
            ld_wdata = $urandom;
            r = int'($urandom % 8);
            ld_addr = (r == 0) ? odd_addrs[$urandom % 4] :
                      (r == 1) ? ((32'($urandom_range(0, 63)) << 2) | 32'h1) :
                      (32'($urandom_range(0, 63)) << 2);
            step();
        end

        // Asynchronous reset mid-LOAD with a read return outstanding.
        idle();
        ld(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        for (int k = 0; k < 4 && m_mode != 2; k++) step();
        ld(1'b1, 1'b1, 32'h2, 32'h0, 1'b0); step();
        ld(1'b1, 1'b0, 32'h10, 32'h0, 1'b0); step();
        chk("pre-rst rvalid", 32'(ld_rvalid), 32'd1);
        chk("pre-rst err", 32'(ld_err), 32'd1);
        ld(1'b1, 1'b1, 32'h20, 32'hCAFE_F00D, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst rvalid", 32'(ld_rvalid), 32'd0);
        chk("arst civ", 32'(core_instr_valid), 32'd0);
        chk("arst err", 32'(ld_err), 32'd0);
        chk("arst cnt", 32'(ld_wr_cnt), 32'd0);
        chk("arst halt", 32'(core_halt), 32'd1);
        chk("arst mem_wr", 32'(mem_wr), 32'd0);
        chk("arst mem_rd", 32'(mem_rd), 32'd0);
        chk("arst d0 halt", 32'(d0_core_halt), 32'd0);
        idle();
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        model_reset();
        core_fetch_en = 1'b1; core_pc = 32'h10; step();
        chk("d0 run after rst", 32'(d0_core_halt), 32'd0);
        chk("d0 fetch valid", 32'(d0_civ), 32'd1);

        // Write counter saturation.
        core_fetch_en = 1'b0;
        for (int i = 0; i < 65540; i++) begin
            ld(1'b1, 1'b1, 32'($urandom_range(0, 1023)) << 2, $urandom, 1'b0);
            step();
        end
        chk("cnt saturated", 32'(ld_wr_cnt), 32'h0000_FFFF);
        idle();
        step();
        chk("cnt holds", 32'(ld_wr_cnt), 32'h0000_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
